// File: rtl/way_replacement_controller_if.sv
// Core-side request/response, way-array and memory handshakes
// for one cache set, bundled for the replacement controller.
interface way_replacement_controller_if #(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32
);
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
    localparam int TAG_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;

    logic                              req_valid;
    logic                              req_ready;
    logic [ADDRESS_WIDTH-1:0]          req_addr;
    logic                              req_write;
    logic [NUM_WAYS-1:0]               way_valid;
    logic [NUM_WAYS-1:0]               way_dirty;
    logic [NUM_WAYS*TAG_WIDTH-1:0]     way_tag;
    logic [NUM_WAYS-1:0]               access;
    logic [NUM_WAYS-1:0]               allocate;
    logic [NUM_WAYS-1:0]               wen;
    logic [NUM_WAYS*COUNTER_WIDTH-1:0] way_age;
    logic [NUM_WAYS-1:0]               expired;
    logic                              wb_valid;
    logic                              wb_ready;
    logic [NUM_WAYS-1:0]               wb_way;
    logic                              fill_valid;
    logic                              fill_ready;
    logic [ADDRESS_WIDTH-1:0]          fill_addr;
    logic                              resp_valid;
    logic                              resp_hit;
    logic [NUM_WAYS-1:0]               resp_way;

    modport master (
        output req_valid, req_addr, req_write,
        output way_valid, way_dirty, way_tag,
        output wb_ready, fill_ready,
        input  req_ready, access, allocate, wen,
        input  way_age, expired, wb_valid, wb_way,
        input  fill_valid, fill_addr,
        input  resp_valid, resp_hit, resp_way
    );

    modport slave (
        input  req_valid, req_addr, req_write,
        input  way_valid, way_dirty, way_tag,
        input  wb_ready, fill_ready,
        output req_ready, access, allocate, wen,
        output way_age, expired, wb_valid, wb_way,
        output fill_valid, fill_addr,
        output resp_valid, resp_hit, resp_way
    );
endinterface

// File: rtl/way_replacement_controller.sv
// Per-set true-LRU lookup/replacement sequencer.
// Define EVICT_WRITEBACK_EN for dirty-victim writeback; otherwise write-through.
module way_replacement_controller #(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32
) (
    input logic clk,
    input logic rst_n,
    way_replacement_controller_if.slave bus
);
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
    localparam int TAG_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam int IDX_WIDTH = $clog2(NUM_WAYS);
    localparam logic [COUNTER_WIDTH-1:0] OLDEST =
        COUNTER_WIDTH'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
`ifdef EVICT_WRITEBACK_EN
        WRITEBACK,
`endif
        FILL,
        RESPOND
    } state_t;

    state_t state;
    state_t nextState;

    logic [TAG_WIDTH-1:0]     tagQ;
    logic                     writeQ;
    logic [IDX_WIDTH-1:0]     victimQ;
    logic                     respHitQ;
    logic [NUM_WAYS-1:0]      respWayQ;
    logic [COUNTER_WIDTH-1:0] age [NUM_WAYS];

    logic                 hit;
    logic [IDX_WIDTH-1:0] hitIdx;
    logic [IDX_WIDTH-1:0] invIdx;
    logic [IDX_WIDTH-1:0] expIdx;
    logic [IDX_WIDTH-1:0] victimIdx;
    logic                 anyInvalid;
    logic                 victimDirty;
    logic [NUM_WAYS-1:0]  hitHot;
    logic [NUM_WAYS-1:0]  victimHot;
    logic [NUM_WAYS-1:0]  victimQHot;
    logic                 touch;
    logic [IDX_WIDTH-1:0] touchIdx;
    logic                 unusedBits;

    // Downward scans so the lowest matching index is the one kept.
    always_comb begin
        hit = 1'b0;
        hitIdx = '0;
        invIdx = '0;
        expIdx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.way_valid[i] &&
                bus.way_tag[i*TAG_WIDTH +: TAG_WIDTH] == tagQ) begin
                hit = 1'b1;
                hitIdx = IDX_WIDTH'(i);
            end
            if (!bus.way_valid[i]) invIdx = IDX_WIDTH'(i);
            if (age[i] == OLDEST) expIdx = IDX_WIDTH'(i);
        end
        anyInvalid = ~&bus.way_valid;
        victimIdx = anyInvalid ? invIdx : expIdx;
    end

    assign hitHot = NUM_WAYS'(1) << hitIdx;
    assign victimHot = NUM_WAYS'(1) << victimIdx;
    assign victimQHot = NUM_WAYS'(1) << victimQ;

`ifdef EVICT_WRITEBACK_EN
    assign victimDirty = !anyInvalid && bus.way_dirty[victimIdx];
    assign unusedBits = ^bus.req_addr[OFFSET_WIDTH-1:0];
`else
    assign victimDirty = 1'b0;
    assign unusedBits = ^{bus.req_addr[OFFSET_WIDTH-1:0],
                          bus.way_dirty, bus.wb_ready};
`endif

    always_comb begin
        nextState = state;
        bus.req_ready = 1'b0;
        bus.access = '0;
        bus.allocate = '0;
        bus.wen = '0;
        bus.wb_valid = 1'b0;
        bus.wb_way = '0;
        bus.fill_valid = 1'b0;
        bus.resp_valid = 1'b0;
        touch = 1'b0;
        touchIdx = victimQ;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) nextState = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.access = hitHot;
                    bus.wen = writeQ ? hitHot : '0;
                    touch = 1'b1;
                    touchIdx = hitIdx;
                    nextState = RESPOND;
                end else if (victimDirty) begin
`ifdef EVICT_WRITEBACK_EN
                    nextState = WRITEBACK;
`else
                    nextState = FILL;
`endif
                end else begin
                    nextState = FILL;
                end
            end
`ifdef EVICT_WRITEBACK_EN
            WRITEBACK: begin
                bus.wb_valid = 1'b1;
                bus.wb_way = victimQHot;
                if (bus.wb_ready) nextState = FILL;
            end
`endif
            FILL: begin
                bus.fill_valid = 1'b1;
                if (bus.fill_ready) begin
                    bus.allocate = victimQHot;
                    bus.wen = writeQ ? victimQHot : '0;
                    touch = 1'b1;
                    nextState = RESPOND;
                end
            end
            RESPOND: begin
                bus.resp_valid = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tagQ <= '0;
            writeQ <= 1'b0;
            victimQ <= '0;
            respHitQ <= 1'b0;
            respWayQ <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && bus.req_valid) begin
                tagQ <= bus.req_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                writeQ <= bus.req_write;
            end
            if (state == LOOKUP) begin
                respHitQ <= hit;
                respWayQ <= hit ? hitHot : victimHot;
                if (!hit) victimQ <= victimIdx;
            end
        end
    end

    // Ages stay a permutation: only younger ways move up by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WAYS; i++)
                age[i] <= COUNTER_WIDTH'(i);
        end else if (touch) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (IDX_WIDTH'(i) == touchIdx)
                    age[i] <= '0;
                else if (age[i] < age[touchIdx])
                    age[i] <= age[i] + COUNTER_WIDTH'(1);
            end
        end
    end

    always_comb begin
        bus.way_age = '0;
        bus.expired = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            bus.way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH] = age[i];
            bus.expired[i] = (age[i] == OLDEST);
        end
    end

    assign bus.fill_addr = {tagQ, {OFFSET_WIDTH{1'b0}}};
    assign bus.resp_hit = respHitQ;
    assign bus.resp_way = respWayQ;
endmodule

// File: tb/tb_way_replacement_controller.sv
// Scoreboard bench for way_replacement_controller: expected
// responses queued at request time, checked on resp_valid.
module tb_way_replacement_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    way_replacement_controller_if bus ();

    way_replacement_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        hit;
        logic [3:0]  way;
        int          lat;
        int          srel;
        logic [3:0]  acc;
        logic [3:0]  alloc;
        logic [3:0]  wen;
        int          wbc;
        logic [3:0]  wbWay;
        logic [31:0] fa;
    } exp_t;

    exp_t sb [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // External way array: follows the controller's strobes.
    logic [3:0]  mValid = '0;
    logic [3:0]  mDirty = '0;
    logic [26:0] mTag [4] = '{default: '0};
    logic [3:0]  forceDirty = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.allocate[i]) begin
                mValid[i] <= 1'b1;
                mTag[i] <= bus.fill_addr[31:5];
                mDirty[i] <= bus.wen[i];
            end else if (bus.access[i] && bus.wen[i]) begin
                mDirty[i] <= 1'b1;
            end
        end
    end

    assign bus.way_valid = mValid;
    assign bus.way_dirty = mDirty | forceDirty;
    assign bus.way_tag = {mTag[3], mTag[2], mTag[1], mTag[0]};

    // Writeback sink: accepts after wbHold cycles of wb_valid.
    int wbHold = 3;
    int wbSeen = 0;
    always @(negedge clk) begin
        if (bus.wb_valid) begin
            wbSeen = wbSeen + 1;
            bus.wb_ready = (wbSeen >= wbHold);
        end else begin
            wbSeen = 0;
            bus.wb_ready = 1'b0;
        end
    end

    int          t0 = 0;
    int          strobeRel = 0;
    int          wbCnt = 0;
    logic [3:0]  accSeen = '0;
    logic [3:0]  allocSeen = '0;
    logic [3:0]  wenSeen = '0;
    logic [3:0]  wbWaySeen = '0;
    logic [31:0] faSeen = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready) begin
                t0 = cyc;
                strobeRel = 0;
                wbCnt = 0;
                accSeen = '0;
                allocSeen = '0;
                wenSeen = '0;
                wbWaySeen = '0;
                faSeen = '0;
            end
            if (|(bus.access | bus.allocate)) strobeRel = cyc - t0;
            accSeen |= bus.access;
            allocSeen |= bus.allocate;
            wenSeen |= bus.wen;
            if (bus.wb_valid) begin
                wbCnt++;
                wbWaySeen |= bus.wb_way;
            end
            if (bus.fill_valid) faSeen = bus.fill_addr;
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_hit", bus.resp_hit, e.hit);
                    chk("resp_way", bus.resp_way, e.way);
                    chk("latency", cyc - t0, e.lat);
                    chk("strobe_cycle", strobeRel, e.srel);
                    chk("access", accSeen, e.acc);
                    chk("allocate", allocSeen, e.alloc);
                    chk("wen", wenSeen, e.wen);
                    chk("wb_cycles", wbCnt, e.wbc);
                    chk("wb_way", wbWaySeen, e.wbWay);
                    if (!e.hit) chk("fill_addr", faSeen, e.fa);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [26:0] tag,
                                       input logic [4:0] off);
        return {tag, off};
    endfunction

    function automatic exp_t hitExp(input logic [3:0] way,
                                    input logic wr);
        exp_t e;
        e = '{1'b1, way, 2, 1, way, 4'b0, wr ? way : 4'b0,
              0, 4'b0, 32'h0};
        return e;
    endfunction

    function automatic exp_t missExp(input logic [3:0] way,
                                     input logic wr,
                                     input int wbc,
                                     input logic [26:0] tag);
        exp_t e;
        e = '{1'b0, way, 3 + wbc, 2 + wbc, 4'b0, way,
              wr ? way : 4'b0, wbc, wbc > 0 ? way : 4'b0,
              {tag, 5'b0}};
        return e;
    endfunction

    task automatic request(input logic [31:0] addr, input logic wr,
                           input exp_t e);
        @(posedge clk); #1;
        sb.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_addr = addr;
        bus.req_write = wr;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("resp_timeout", sb.size(), 0);
            sb.delete();
        end
        #1;
    endtask

    task automatic ageChk(input string tag, input logic [31:0] ages,
                          input logic [3:0] exp);
        chk({tag, "_age"}, bus.way_age, ages);
        chk({tag, "_expired"}, bus.expired, exp);
    endtask

    logic [26:0] tags [6] = '{27'h0A, 27'h0B, 27'h0C,
                              27'h0D, 27'h0E, 27'h0F};
    int reached;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_write = 1'b0;
        bus.fill_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        ageChk("reset", 32'h03020100, 4'b1000);
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_strobes", {bus.access, bus.allocate, bus.wen}, 0);
        chk("reset_valids",
            {bus.wb_valid, bus.fill_valid, bus.resp_valid}, 0);
        chk("reset_resp", {bus.resp_hit, bus.resp_way, bus.wb_way}, 0);
        chk("reset_fill_addr", bus.fill_addr, 0);

        for (int i = 0; i < 4; i++)
            request(mk(tags[i], 5'(3 + 7 * i)), 1'b0,
                    missExp(4'(1 << i), 1'b0, 0, tags[i]));
        ageChk("filled", 32'h00010203, 4'b0001);

        request(mk(tags[1], 5'h04), 1'b0, hitExp(4'b0010, 1'b0));
        ageChk("hit_b", 32'h01020003, 4'b0001);

        forceDirty = 4'b0001;
`ifdef EVICT_WRITEBACK_EN
        request(mk(tags[4], 5'h1f), 1'b1,
                missExp(4'b0001, 1'b1, 3, tags[4]));
`else
        request(mk(tags[4], 5'h1f), 1'b1,
                missExp(4'b0001, 1'b1, 0, tags[4]));
`endif
        forceDirty = 4'b0000;
        ageChk("miss_e", 32'h02030100, 4'b0100);

        // Abort mid-transaction: victim way2 forced dirty, no handshakes.
        forceDirty = 4'b0100;
        bus.fill_ready = 1'b0;
        wbHold = 100;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr = mk(tags[5], 5'h02);
        bus.req_write = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reached = 0;
        for (int k = 0; k < 20 && reached == 0; k++) begin
            @(negedge clk);
`ifdef EVICT_WRITEBACK_EN
            if (bus.wb_valid) reached = 1;
`else
            if (bus.fill_valid) reached = 1;
`endif
        end
        chk("abort_reached", reached, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_wb_valid", bus.wb_valid, 0);
        chk("abort_fill_valid", bus.fill_valid, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        chk("abort_ready", bus.req_ready, 1);
        ageChk("abort", 32'h03020100, 4'b1000);
        @(negedge clk); #1;
        rst_n = 1'b1;
        forceDirty = 4'b0000;
        bus.fill_ready = 1'b1;
        wbHold = 3;

        request(mk(tags[1], 5'h10), 1'b0, hitExp(4'b0010, 1'b0));
        ageChk("post_reset_hit", 32'h03020001, 4'b1000);

        request(mk(tags[3], 5'h01), 1'b1, hitExp(4'b1000, 1'b1));
        ageChk("write_hit_d", 32'h00030102, 4'b0100);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
